// File: rtl/dtw_core_ctrl_if.sv
// Controller <-> PE-array/front-end bus: squiggle stream in, x-register writes, reference reads, last-PE cost.
// master = controller side, slave = array/front-end side.
interface dtw_core_ctrl_if #(
  parameter int width  = 16,
  parameter int PE_NUM = 32,
  parameter int ADDR_W = 16
);
  localparam int SEL_W = $clog2(PE_NUM);

  logic [width-1:0]  sq_data;
  logic              sq_valid;
  logic              sq_ready;
  logic              x_we;
  logic [SEL_W-1:0]  x_sel;
  logic [width-1:0]  x_data;
  logic              pe_clr;
  logic              running;
  logic              ref_rd;
  logic [ADDR_W-1:0] ref_addr;
  logic [width-1:0]  last_dtwc;

  modport master (
    input  sq_data, sq_valid, last_dtwc,
    output sq_ready, x_we, x_sel, x_data, pe_clr, running, ref_rd, ref_addr
  );

  modport slave (
    output sq_data, sq_valid, last_dtwc,
    input  sq_ready, x_we, x_sel, x_data, pe_clr, running, ref_rd, ref_addr
  );
endinterface

// File: rtl/dtw_core_ctrl.sv
// DTW array sequencer: load PE_NUM samples, clear, stream ref_len addresses, track min last-PE cost; all outputs registered.
// LOAD stalls on sq_valid gaps; optional abort input enabled by `DTW_CTRL_ABORT_EN.
module dtw_core_ctrl #(
  parameter int width  = 16,
  parameter int PE_NUM = 32,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] ref_len,
`ifdef DTW_CTRL_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic [width-1:0]  score,
  output logic [ADDR_W-1:0] score_pos,
  dtw_core_ctrl_if.master   bus
);
  localparam int SEL_W = $clog2(PE_NUM);
  localparam int CW    = ADDR_W + SEL_W + 1;

  typedef enum logic [2:0] {IDLE, LOAD, CLR, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [SEL_W-1:0]  k_q, k_d;
  logic [CW-1:0]     c_q, c_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              sq_ready_q, sq_ready_d, x_we_q, x_we_d;
  logic [SEL_W-1:0]  x_sel_q, x_sel_d;
  logic [width-1:0]  x_data_q, x_data_d;
  logic              pe_clr_q, pe_clr_d, running_q, running_d, ref_rd_q, ref_rd_d;
  logic [ADDR_W-1:0] ref_addr_q, ref_addr_d;
  logic [width-1:0]  score_q, score_d;
  logic [ADDR_W-1:0] score_pos_q, score_pos_d;
  logic [CW-1:0]     len_ext, c_end;

  assign len_ext = CW'(len_q);
  // Last counter value: final reference sample has drained through PE_NUM-1 more PEs.
  assign c_end   = len_ext + CW'(PE_NUM - 2);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    k_d         = k_q;
    c_d         = c_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    sq_ready_d  = sq_ready_q;
    x_we_d      = 1'b0;
    x_sel_d     = x_sel_q;
    x_data_d    = x_data_q;
    pe_clr_d    = 1'b0;
    running_d   = running_q;
    ref_rd_d    = ref_rd_q;
    ref_addr_d  = ref_addr_q;
    score_d     = score_q;
    score_pos_d = score_pos_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d      = 1'b1;
          score_d     = '1;
          score_pos_d = '0;
          if (ref_len != '0) begin
            len_d      = ref_len;
            k_d        = '0;
            sq_ready_d = 1'b1;
            state_d    = LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        if (bus.sq_valid && sq_ready_q) begin
          x_we_d   = 1'b1;
          x_sel_d  = k_q;
          x_data_d = bus.sq_data;
          k_d      = k_q + SEL_W'(1);
          if (k_q == SEL_W'(PE_NUM - 1)) begin
            sq_ready_d = 1'b0;
            pe_clr_d   = 1'b1;
            state_d    = CLR;
          end
        end
      end
      CLR: begin
        c_d        = '0;
        running_d  = 1'b1;
        ref_rd_d   = 1'b1;
        ref_addr_d = '0;
        state_d    = RUN;
      end
      RUN: begin
        // Strict compare keeps the earliest position on ties.
        if (c_q >= CW'(PE_NUM - 1) && bus.last_dtwc < score_q) begin
          score_d     = bus.last_dtwc;
          score_pos_d = c_q[ADDR_W-1:0] - ADDR_W'(PE_NUM - 1);
        end
        if (c_q == c_end) begin
          running_d = 1'b0;
          ref_rd_d  = 1'b0;
          done_d    = 1'b1;
          state_d   = DONE;
        end else begin
          c_d      = c_q + CW'(1);
          ref_rd_d = (c_d < len_ext);
          if (ref_rd_d) ref_addr_d = c_d[ADDR_W-1:0];
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef DTW_CTRL_ABORT_EN
    if (abort && (state_q == LOAD || state_q == CLR || state_q == RUN)) begin
      state_d     = DONE;
      done_d      = 1'b1;
      sq_ready_d  = 1'b0;
      x_we_d      = 1'b0;
      x_sel_d     = x_sel_q;
      x_data_d    = x_data_q;
      pe_clr_d    = 1'b0;
      running_d   = 1'b0;
      ref_rd_d    = 1'b0;
      ref_addr_d  = ref_addr_q;
      k_d         = k_q;
      c_d         = c_q;
      score_d     = score_q;
      score_pos_d = score_pos_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      k_q         <= '0;
      c_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sq_ready_q  <= 1'b0;
      x_we_q      <= 1'b0;
      x_sel_q     <= '0;
      x_data_q    <= '0;
      pe_clr_q    <= 1'b0;
      running_q   <= 1'b0;
      ref_rd_q    <= 1'b0;
      ref_addr_q  <= '0;
      score_q     <= '1;
      score_pos_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      k_q         <= k_d;
      c_q         <= c_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sq_ready_q  <= sq_ready_d;
      x_we_q      <= x_we_d;
      x_sel_q     <= x_sel_d;
      x_data_q    <= x_data_d;
      pe_clr_q    <= pe_clr_d;
      running_q   <= running_d;
      ref_rd_q    <= ref_rd_d;
      ref_addr_q  <= ref_addr_d;
      score_q     <= score_d;
      score_pos_q <= score_pos_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign score        = score_q;
  assign score_pos    = score_pos_q;
  assign bus.sq_ready = sq_ready_q;
  assign bus.x_we     = x_we_q;
  assign bus.x_sel    = x_sel_q;
  assign bus.x_data   = x_data_q;
  assign bus.pe_clr   = pe_clr_q;
  assign bus.running  = running_q;
  assign bus.ref_rd   = ref_rd_q;
  assign bus.ref_addr = ref_addr_q;
endmodule

// File: tb/tb_dtw_core_ctrl.sv
// Directed bench for dtw_core_ctrl with PE_NUM=4: per-cycle vector table for a full job plus corner-case sequences.
`timescale 1ns/1ps
module tb_dtw_core_ctrl;
  localparam int W  = 16;
  localparam int PE = 4;
  localparam int AW = 16;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] ref_len = '0;
  logic          busy, done;
  logic [W-1:0]  score;
  logic [AW-1:0] score_pos;
`ifdef DTW_CTRL_ABORT_EN
  logic          abort = 1'b0;
`endif

  dtw_core_ctrl_if #(.width(W), .PE_NUM(PE), .ADDR_W(AW)) bus ();

  dtw_core_ctrl #(.width(W), .PE_NUM(PE), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ref_len   (ref_len),
`ifdef DTW_CTRL_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .done      (done),
    .score     (score),
    .score_pos (score_pos),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " busy"},      busy, 0);
    chk({tag, " done"},      done, 0);
    chk({tag, " sq_ready"},  bus.sq_ready, 0);
    chk({tag, " x_we"},      bus.x_we, 0);
    chk({tag, " x_sel"},     bus.x_sel, 0);
    chk({tag, " x_data"},    bus.x_data, 0);
    chk({tag, " pe_clr"},    bus.pe_clr, 0);
    chk({tag, " running"},   bus.running, 0);
    chk({tag, " ref_rd"},    bus.ref_rd, 0);
    chk({tag, " ref_addr"},  bus.ref_addr, 0);
    chk({tag, " score"},     score, 16'hFFFF);
    chk({tag, " score_pos"}, score_pos, 0);
  endtask

  // Start a job, feed PE samples back-to-back, then run to done counting running cycles.
  task automatic run_job(input logic [AW-1:0] len, input logic [W-1:0] dtwc,
                         output int run_cnt, output int we_cnt, output bit got_done);
    ref_len = len; start = 1'b1; bus.last_dtwc = dtwc;
    step();
    start = 1'b0; bus.sq_valid = 1'b1;
    run_cnt = 0; we_cnt = 0; got_done = 0;
    for (int t = 0; t < 100; t++) begin
      if (bus.running) run_cnt++;
      if (bus.x_we) we_cnt++;
      if (bus.pe_clr) bus.sq_valid = 1'b0;
      if (done) begin got_done = 1; break; end
      step();
    end
    bus.sq_valid = 1'b0;
  endtask

  typedef struct {
    logic          start;
    logic          sq_valid;
    logic [W-1:0]  sq_data;
    logic [W-1:0]  dtwc;
    logic          busy, done, sq_ready, x_we;
    logic [SW-1:0] x_sel;
    logic [W-1:0]  x_data;
    logic          pe_clr, running, ref_rd;
    logic [AW-1:0] ref_addr;
    logic [W-1:0]  score;
    logic [AW-1:0] pos;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(logic st, logic v, logic [W-1:0] d, logic [W-1:0] dt,
                              logic b, logic dn, logic rdy, logic we, logic [SW-1:0] sel,
                              logic [W-1:0] xd, logic clr, logic run, logic rd,
                              logic [AW-1:0] addr, logic [W-1:0] sc, logic [AW-1:0] p);
    vec_t r;
    r.start = st; r.sq_valid = v; r.sq_data = d; r.dtwc = dt;
    r.busy = b; r.done = dn; r.sq_ready = rdy; r.x_we = we; r.x_sel = sel; r.x_data = xd;
    r.pe_clr = clr; r.running = run; r.ref_rd = rd; r.ref_addr = addr; r.score = sc; r.pos = p;
    return r;
  endfunction

  int  run_cnt, we_cnt, gap_beats;
  bit  got_done;
  logic gap_pat [7];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // inputs: start vld data dtwc | busy done rdy we sel xdata clr run rd addr score pos
    tbl[0]  = mk(1, 0, 16'h0000, 0, 1, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'hFFFF, 0);
    tbl[1]  = mk(0, 1, 16'h1111, 0, 1, 0, 1, 1, 0, 16'h1111, 0, 0, 0, 0, 16'hFFFF, 0);
    tbl[2]  = mk(0, 1, 16'h2222, 0, 1, 0, 1, 1, 1, 16'h2222, 0, 0, 0, 0, 16'hFFFF, 0);
    tbl[3]  = mk(0, 1, 16'h3333, 0, 1, 0, 1, 1, 2, 16'h3333, 0, 0, 0, 0, 16'hFFFF, 0);
    tbl[4]  = mk(0, 1, 16'h4444, 0, 1, 0, 0, 1, 3, 16'h4444, 1, 0, 0, 0, 16'hFFFF, 0);
    tbl[5]  = mk(0, 1, 16'h5555, 0, 1, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 0, 16'hFFFF, 0);
    tbl[6]  = mk(0, 1, 16'h0000, 9, 1, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 1, 16'hFFFF, 0);
    tbl[7]  = mk(0, 1, 16'h0000, 9, 1, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 2, 16'hFFFF, 0);
    tbl[8]  = mk(0, 1, 16'h0000, 9, 1, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 3, 16'hFFFF, 0);
    tbl[9]  = mk(0, 1, 16'h0000, 7, 1, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 4, 16'd7, 0);
    tbl[10] = mk(0, 1, 16'h0000, 5, 1, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 5, 16'd5, 1);
    tbl[11] = mk(0, 1, 16'h0000, 3, 1, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 6, 16'd3, 2);
    tbl[12] = mk(0, 1, 16'h0000, 8, 1, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 7, 16'd3, 2);
    tbl[13] = mk(0, 1, 16'h0000, 3, 1, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'd3, 2);
    tbl[14] = mk(0, 1, 16'h0000, 6, 1, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'd3, 2);
    tbl[15] = mk(0, 1, 16'h0000, 4, 1, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'd3, 2);
    tbl[16] = mk(0, 1, 16'h0000, 9, 1, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'd3, 2);
    tbl[17] = mk(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 16'd3, 2);

    bus.sq_valid = 1'b0; bus.sq_data = '0; bus.last_dtwc = '0;

    step(); step();
    chk_reset("reset");
    rst = 1'b0;
    step();
    chk("idle busy", busy, 0);

    // Full job, ref_len=8, one row per clock
    ref_len = 8;
    for (int i = 0; i < 18; i++) begin
      start = tbl[i].start; bus.sq_valid = tbl[i].sq_valid;
      bus.sq_data = tbl[i].sq_data; bus.last_dtwc = tbl[i].dtwc;
      step();
      chk($sformatf("row%0d busy", i),      busy, tbl[i].busy);
      chk($sformatf("row%0d done", i),      done, tbl[i].done);
      chk($sformatf("row%0d sq_ready", i),  bus.sq_ready, tbl[i].sq_ready);
      chk($sformatf("row%0d x_we", i),      bus.x_we, tbl[i].x_we);
      if (tbl[i].x_we) begin
        chk($sformatf("row%0d x_sel", i),  bus.x_sel, tbl[i].x_sel);
        chk($sformatf("row%0d x_data", i), bus.x_data, tbl[i].x_data);
      end
      chk($sformatf("row%0d pe_clr", i),    bus.pe_clr, tbl[i].pe_clr);
      chk($sformatf("row%0d running", i),   bus.running, tbl[i].running);
      chk($sformatf("row%0d ref_rd", i),    bus.ref_rd, tbl[i].ref_rd);
      if (tbl[i].ref_rd)
        chk($sformatf("row%0d ref_addr", i), bus.ref_addr, tbl[i].ref_addr);
      chk($sformatf("row%0d score", i),     score, tbl[i].score);
      chk($sformatf("row%0d score_pos", i), score_pos, tbl[i].pos);
    end

    // Gapped squiggle stream: 1,0,0,1,1,0,1
    gap_pat[0] = 1; gap_pat[1] = 0; gap_pat[2] = 0; gap_pat[3] = 1;
    gap_pat[4] = 1; gap_pat[5] = 0; gap_pat[6] = 1;
    ref_len = 2; start = 1'b1; bus.last_dtwc = 16'h0020;
    step();
    start = 1'b0; gap_beats = 0;
    for (int i = 0; i < 7; i++) begin
      bus.sq_valid = gap_pat[i]; bus.sq_data = 16'h00A0 + 16'(i);
      step();
      chk($sformatf("gap%0d x_we", i), bus.x_we, gap_pat[i]);
      if (bus.x_we) begin
        chk($sformatf("gap%0d x_sel", i),  bus.x_sel, gap_beats);
        chk($sformatf("gap%0d x_data", i), bus.x_data, 16'h00A0 + 16'(i));
        gap_beats++;
      end
      chk($sformatf("gap%0d pe_clr", i), bus.pe_clr, (i == 6) ? 1 : 0);
    end
    chk("gap beats", gap_beats, 4);
    chk("gap sq_ready after last", bus.sq_ready, 0);
    bus.sq_valid = 1'b0;
    run_cnt = 0; got_done = 0;
    for (int t = 0; t < 50; t++) begin
      if (bus.running) run_cnt++;
      if (done) begin got_done = 1; break; end
      step();
    end
    chk("gap done seen", got_done, 1);
    chk("gap running cycles", run_cnt, 5);
    chk("gap score", score, 16'h0020);
    chk("gap score_pos", score_pos, 0);
    step();

    // Zero-length reference
    ref_len = 0; start = 1'b1;
    step();
    start = 1'b0;
    chk("len0 done", done, 1);
    chk("len0 busy", busy, 1);
    chk("len0 score", score, 16'hFFFF);
    chk("len0 score_pos", score_pos, 0);
    chk("len0 x_we", bus.x_we, 0);
    chk("len0 running", bus.running, 0);
    step();
    chk("len0 done drop", done, 0);
    chk("len0 idle", busy, 0);
    chk("len0 no running", bus.running, 0);

    // start during RUN ignored, then rst at RUN c=5
    ref_len = 8; start = 1'b1; bus.last_dtwc = 16'h0050;
    step();
    start = 1'b0; bus.sq_valid = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.sq_valid = 1'b0;
    chk("rstseq clr", bus.pe_clr, 1);
    step();
    chk("rstseq c0 running", bus.running, 1);
    step(); step();
    start = 1'b1; ref_len = 3;
    step();
    start = 1'b0;
    chk("rstseq start ignored busy", busy, 1);
    chk("rstseq start ignored running", bus.running, 1);
    chk("rstseq c3 ref_addr", bus.ref_addr, 3);
    chk("rstseq c3 no x_we", bus.x_we, 0);
    step(); step();
    chk("rstseq c5 ref_addr", bus.ref_addr, 5);
    chk("rstseq c5 score", score, 16'h0050);
    rst = 1'b1;
    step();
    chk_reset("midjob rst");
    rst = 1'b0;
    step();
    run_job(3, 16'h0030, run_cnt, we_cnt, got_done);
    chk("postrst done seen", got_done, 1);
    chk("postrst x_we beats", we_cnt, 4);
    chk("postrst running cycles", run_cnt, 6);
    chk("postrst score", score, 16'h0030);
    chk("postrst score_pos", score_pos, 0);
    step();

`ifdef DTW_CTRL_ABORT_EN
    // Abort at RUN c=5 after best 5 at pos 1
    ref_len = 8; start = 1'b1; bus.last_dtwc = 16'd9;
    step();
    start = 1'b0; bus.sq_valid = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.sq_valid = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      bus.last_dtwc = (c == 4) ? 16'd5 : 16'd9;
      step();
    end
    chk("abort pre running", bus.running, 1);
    abort = 1'b1; bus.last_dtwc = 16'd50;
    step();
    abort = 1'b0;
    chk("abort done", done, 1);
    chk("abort running", bus.running, 0);
    chk("abort ref_rd", bus.ref_rd, 0);
    chk("abort score", score, 5);
    chk("abort score_pos", score_pos, 1);
    step();
    chk("abort idle", busy, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
